// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for blocks that sit on the item FIFO read side.
//   - state_t        : read-side FSM states (IDLE, POP_WAIT, SEND)
//   - calc_nbytes    : number of output symbols per FIFO word
//   - calc_idx_width : width of a symbol index, never less than one bit
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POP_WAIT = 2'd1,
    SEND     = 2'd2
  } state_t;

  function automatic int calc_nbytes(input int item_bits, input int byte_bits);
    return item_bits / byte_bits;
  endfunction

  function automatic int calc_idx_width(input int item_bits, input int byte_bits);
    int n;
    n = item_bits / byte_bits;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker
//   Pops words from the item FIFO and replays each one as a stream of
//   BYTE_BITS-wide symbols on a valid/ready interface. A word is only popped
//   when the block is idle or is completing the last byte of the previous
//   word, so no word is ever held in a second buffer.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   fifo_data   : FIFO read data, valid the cycle after fifo_read
//   fifo_empty  : FIFO empty flag
//   fifo_read   : combinational pop strobe
//   byte_data   : registered output symbol
//   byte_valid  : byte_data is valid
//   byte_ready  : sink accepts the symbol on byte_valid && byte_ready
//   byte_last   : byte_data is the final symbol of the word
//   busy        : block is not in IDLE
//   words_sent  : wrapping count of completely transferred words
module fifo_byte_unpacker
  import fifo_pkg::*;
#(
  parameter int ITEM_SIZE_BITS = 32,
  parameter int BYTE_BITS      = 8,
  parameter int MSB_FIRST      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ITEM_SIZE_BITS-1:0] fifo_data,
  input  logic                      fifo_empty,
  output logic                      fifo_read,
  output logic [BYTE_BITS-1:0]      byte_data,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      byte_last,
  output logic                      busy,
  output logic [15:0]               words_sent
);

  localparam int NBYTES = calc_nbytes(ITEM_SIZE_BITS, BYTE_BITS);
  localparam int IDX_W  = calc_idx_width(ITEM_SIZE_BITS, BYTE_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if (ITEM_SIZE_BITS % BYTE_BITS != 0) begin : g_bad_width
    $fatal(1, "ITEM_SIZE_BITS must be a multiple of BYTE_BITS");
  end

  state_t                    state_r;
  state_t                    next_state_s;
  logic [ITEM_SIZE_BITS-1:0] shift_r;
  logic [ITEM_SIZE_BITS-1:0] shift_next_s;
  logic [IDX_W-1:0]          idx_r;
  logic [BYTE_BITS-1:0]      byte_data_r;
  logic                      byte_valid_r;
  logic                      byte_last_r;
  logic                      busy_r;
  logic [15:0]               words_sent_r;
  logic                      fifo_read_s;
  logic                      load_s;
  logic                      advance_s;
  logic                      handshake_s;
  logic                      last_hs_s;

  // The symbol to present next always sits at the "leading" end of the word,
  // so the shift register is moved towards that end after each handshake.
  function automatic logic [BYTE_BITS-1:0] lead_byte(input logic [ITEM_SIZE_BITS-1:0] word);
    if (MSB_FIRST != 0) begin
      return word[ITEM_SIZE_BITS-1 -: BYTE_BITS];
    end else begin
      return word[BYTE_BITS-1:0];
    end
  endfunction

  // Shifted copy of the word used when advancing to the next symbol.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shift_next_s = shift_r << BYTE_BITS;
    end else begin
      shift_next_s = shift_r >> BYTE_BITS;
    end
  end

  // Next-state logic, pop strobe and datapath control.
  always_comb begin
    next_state_s = state_r;
    fifo_read_s  = 1'b0;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    handshake_s  = byte_valid_r && byte_ready;
    last_hs_s    = handshake_s && byte_last_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_read_s  = 1'b1;
          next_state_s = POP_WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      POP_WAIT: begin
        // FIFO read latency: data requested last cycle is on fifo_data now.
        load_s       = 1'b1;
        next_state_s = SEND;
      end
      SEND: begin
        if (last_hs_s) begin
          // Back-to-back pop keeps the gap between words to a single cycle.
          if (!fifo_empty) begin
            fifo_read_s  = 1'b1;
            next_state_s = POP_WAIT;
          end else begin
            next_state_s = IDLE;
          end
        end else if (handshake_s) begin
          advance_s    = 1'b1;
          next_state_s = SEND;
        end else begin
          next_state_s = SEND;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state, shift register, output registers and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= {ITEM_SIZE_BITS{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      byte_data_r  <= {BYTE_BITS{1'b0}};
      byte_valid_r <= 1'b0;
      byte_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      words_sent_r <= 16'd0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      if (load_s) begin
        shift_r      <= fifo_data;
        idx_r        <= {IDX_W{1'b0}};
        byte_data_r  <= lead_byte(fifo_data);
        byte_valid_r <= 1'b1;
        byte_last_r  <= (LAST_IDX == {IDX_W{1'b0}});
      end else if (advance_s) begin
        shift_r     <= shift_next_s;
        idx_r       <= idx_r + IDX_W'(1);
        byte_data_r <= lead_byte(shift_next_s);
        byte_last_r <= ((idx_r + IDX_W'(1)) == LAST_IDX);
      end else if (last_hs_s) begin
        byte_valid_r <= 1'b0;
        byte_last_r  <= 1'b0;
      end
      if (last_hs_s) begin
        words_sent_r <= words_sent_r + 16'd1;
      end
    end
  end

  assign fifo_read  = fifo_read_s && !rst;
  assign byte_data  = byte_data_r;
  assign byte_valid = byte_valid_r;
  assign byte_last  = byte_last_r;
  assign busy       = busy_r;
  assign words_sent = words_sent_r;

endmodule
